// File: rtl/pass_keeper_pkg.sv
// Shared sizing and FSM encoding for the pass-keeper CAM.
package pass_keeper_pkg;
  localparam int KEY_W  = 64;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} cam_state_t;
endpackage

// File: rtl/cam_entry_array.sv
// Key storage with per-entry valid bits; one write port, one indexed read port.
module cam_entry_array #(
  parameter int KEY_W = pass_keeper_pkg::KEY_W,
  parameter int DEPTH = pass_keeper_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [KEY_W-1:0]  wkey,
  input  logic              clr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [KEY_W-1:0]  rkey,
  output logic              rvalid
);
  logic [KEY_W-1:0] keys [DEPTH];
  logic [DEPTH-1:0] valid;

  // Keys carry no reset; a stale key is harmless while its valid bit is low.
  always_ff @(posedge clk) begin
    if (we) keys[waddr] <= wkey;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    valid        <= '0;
    else if (clr) valid       <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end

  assign rkey   = keys[raddr];
  assign rvalid = valid[raddr];
endmodule

// File: rtl/pass_cam.sv
// Sequential-scan CAM: one entry compared per cycle, lowest matching index wins.
module pass_cam #(
  parameter int KEY_W = pass_keeper_pkg::KEY_W,
  parameter int DEPTH = pass_keeper_pkg::DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_start,
  input  logic [KEY_W-1:0]  search_key,
  input  logic              cam_write_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic              clear,
  output logic              match,
  output logic [ADDR_W-1:0] match_addr,
  output logic [ADDR_W-1:0] max_add,
  output logic              empty,
  output logic              busy,
  output logic              search_done,
  output logic              wr_drop
);
  import pass_keeper_pkg::*;

  cam_state_t        state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [KEY_W-1:0]  key_q, rd_key;
  logic              rd_valid, hit, last, start_ok, wr_ok;

  assign start_ok = (state == IDLE) && cam_start && !clear;
  assign wr_ok    = (state == IDLE) && cam_write_en && !cam_start && !clear;
  assign hit      = rd_valid && (rd_key == key_q);
  // idx never needs to wrap: the scan stops at max_add, which is at most DEPTH-1.
  assign last     = empty || (idx == max_add) || (idx == ADDR_W'(DEPTH-1));

  cam_entry_array #(.KEY_W(KEY_W), .DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (wr_ok),
    .waddr  (wr_addr),
    .wkey   (wr_key),
    .clr    (clear),
    .raddr  (idx),
    .rkey   (rd_key),
    .rvalid (rd_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = SCAN;
      SCAN:    if (hit || last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_comb begin
    busy        = (state == SCAN);
    search_done = (state == DONE) && !clear;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match      <= 1'b0;
      match_addr <= '0;
      max_add    <= '0;
      empty      <= 1'b1;
      wr_drop    <= 1'b0;
      idx        <= '0;
      key_q      <= '0;
    end else begin
      wr_drop <= cam_write_en && ((state != IDLE) || cam_start);
      if (clear) begin
        match      <= 1'b0;
        match_addr <= '0;
        max_add    <= '0;
        empty      <= 1'b1;
      end else begin
        // Valid bits only ever get set between clears, so a running max is exact.
        if (wr_ok) begin
          empty <= 1'b0;
          if (wr_addr > max_add) max_add <= wr_addr;
        end
        if (start_ok) begin
          key_q      <= search_key;
          match      <= 1'b0;
          match_addr <= '0;
          idx        <= '0;
        end else if (state == SCAN) begin
          if (hit) begin
            match      <= 1'b1;
            match_addr <= idx;
          end else if (!last) begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pass_cam.sv
// Directed + randomized check of pass_cam against an array-based reference model.
module tb_pass_cam;
  logic        clk, rst, cam_start, cam_write_en, clear;
  logic [63:0] search_key, wr_key;
  logic [3:0]  wr_addr;
  logic        match, empty, busy, search_done, wr_drop;
  logic [3:0]  match_addr, max_add;

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] m_key [16];
  bit          m_val [16];

  pass_cam dut (
    .clk(clk), .rst(rst), .cam_start(cam_start), .search_key(search_key),
    .cam_write_en(cam_write_en), .wr_addr(wr_addr), .wr_key(wr_key), .clear(clear),
    .match(match), .match_addr(match_addr), .max_add(max_add), .empty(empty),
    .busy(busy), .search_done(search_done), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_max();
    for (int i = 15; i >= 0; i--) if (m_val[i]) return i;
    return 0;
  endfunction

  function automatic bit m_empty();
    for (int i = 0; i < 16; i++) if (m_val[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_match"}, match, 0);
    chk({pfx, "_match_addr"}, match_addr, 0);
    chk({pfx, "_max_add"}, max_add, 0);
    chk({pfx, "_empty"}, empty, 1);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_search_done"}, search_done, 0);
    chk({pfx, "_wr_drop"}, wr_drop, 0);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic wr(input logic [3:0] a, input logic [63:0] k);
    cam_write_en = 1'b1; wr_addr = a; wr_key = k;
    @(posedge clk); @(negedge clk);
    cam_write_en = 1'b0;
    m_key[a] = k; m_val[a] = 1'b1;
    chk("wr_max_add", max_add, 64'(m_max()));
    chk("wr_empty", empty, m_empty());
    chk("wr_no_drop", wr_drop, 0);
  endtask

  task automatic clr();
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    m_clear();
    chk("clr_empty", empty, 1);
    chk("clr_max_add", max_add, 0);
    chk("clr_match", match, 0);
  endtask

  // Search for key; optionally raise a (to-be-dropped) write in cycle wcyc (-1 = none).
  task automatic search(input logic [63:0] key, input int wcyc,
                        input logic [3:0] wa, input logic [63:0] wk);
    bit ehit, done, pend;
    logic [3:0] eaddr;
    int ecyc, c;
    ehit = 1'b0; eaddr = '0;
    for (int i = 15; i >= 0; i--)
      if (m_val[i] && m_key[i] == key) begin ehit = 1'b1; eaddr = 4'(i); end
    ecyc = ehit ? int'(eaddr) + 2 : (m_empty() ? 2 : m_max() + 2);

    cam_start = 1'b1; search_key = key;
    cam_write_en = (wcyc == 0); wr_addr = wa; wr_key = wk;
    pend = (wcyc == 0);
    @(posedge clk); @(negedge clk);
    cam_start = 1'b0; search_key = {$urandom, $urandom};
    c = 1; done = 1'b0;
    while (!done && c < 40) begin
      cam_write_en = (c == wcyc);
      if (pend) begin chk("wr_drop", wr_drop, 1); pend = 1'b0; end
      if (c == wcyc) pend = 1'b1;
      chk("busy_scan", busy, !search_done);
      if (search_done) done = 1'b1;
      else begin @(posedge clk); @(negedge clk); c++; end
    end
    chk("done_seen", done, 1);
    chk("latency", 64'(c), 64'(ecyc));
    chk("match", match, ehit);
    chk("match_addr", match_addr, eaddr);
    cam_write_en = 1'b0;
    @(posedge clk); @(negedge clk);
    if (pend) chk("wr_drop_late", wr_drop, 1);
    chk("done_one_cycle", search_done, 0);
    chk("busy_idle", busy, 0);
    chk("match_held", match, ehit);
  endtask

  initial begin
    rst = 1'b0; cam_start = 1'b0; cam_write_en = 1'b0; clear = 1'b0;
    search_key = '0; wr_key = '0; wr_addr = '0;
    m_clear();
    for (int i = 0; i < 16; i++) m_key[i] = '0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // Empty CAM
    search(64'h1234, -1, 0, 0);
    chk("empty_after_search", empty, 1);
    chk("max_add_empty", max_add, 0);

    // Basic hit / miss
    for (int i = 0; i < 4; i++) wr(4'(i), 64'hA0 + 64'(i));
    chk("max_add_3", max_add, 3);
    search(64'hA2, -1, 0, 0);
    search(64'hFF, -1, 0, 0);

    // Duplicates: lowest index wins; overwrite leaves max_add alone
    wr(4'd1, 64'hB5);
    wr(4'd3, 64'hB5);
    search(64'hB5, -1, 0, 0);

    // Write during SCAN is dropped and doesn't disturb the result
    search(64'hA2, 2, 4'd0, 64'hA2);
    search(64'hA0, -1, 0, 0);
    // Write coincident with cam_start is dropped; search still runs
    search(64'hB5, 0, 4'd4, 64'hB5);
    chk("max_add_after_drop", max_add, 3);

    // Clear mid-SCAN aborts with no search_done
    cam_start = 1'b1; search_key = 64'hFF;
    @(posedge clk); @(negedge clk);
    cam_start = 1'b0;
    @(posedge clk); @(negedge clk);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    m_clear();
    chk("clr_scan_busy", busy, 0);
    chk("clr_scan_done", search_done, 0);
    chk("clr_scan_empty", empty, 1);
    chk("clr_scan_max", max_add, 0);
    chk("clr_scan_match", match, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("clr_no_done", search_done, 0);
    end

    // Async reset mid-SCAN
    wr(4'd5, 64'hD5);
    cam_start = 1'b1; search_key = 64'hEE;
    @(posedge clk); @(negedge clk);
    cam_start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    m_clear();
    search(64'hD5, -1, 0, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 7) == 0) clr();
      else
        for (int w = 0; w < int'($urandom_range(1, 3)); w++)
          wr(4'($urandom_range(0, 15)), 64'hC0 + 64'($urandom_range(0, 5)));
      search(($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'hC0 + 64'($urandom_range(0, 5)),
             int'($urandom_range(0, 2)) - 1, 4'($urandom_range(0, 15)), 64'hC0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
